// File: rtl/quicksort_ctrl.sv
// quicksort_ctrl
// Iterative quicksort controller. It owns the working array and an explicit
// stack of pending {lo, hi} sub-ranges. For each range it hands the array to
// an external partition block. It then takes back the partitioned array and
// pivot index, pushes the resulting sub-ranges and continues. When the stack
// is empty it presents the sorted array with a one-cycle valid pulse.
//
// Ports
//   clock, reset     rising-edge clock, synchronous active-high reset
//   array_in         unsorted array, element 0 in the MSBs
//   sort_start       sort request, only honoured while idle
//   part_array_out   working array presented to the partition block
//   part_lo_ind      low index of the range being partitioned
//   part_hi_ind      high index (pivot position) of that range
//   part_start       one-cycle partition request
//   part_array_in    partitioned array returned by the partition block
//   part_valid       one-cycle completion strobe from the partition block
//   part_pivot_ind   final pivot index reported by the partition block
//   array_out        last sorted result, held until the next completion
//   sort_valid       one-cycle completion pulse
//   busy             high whenever a sort is in progress
//   sort_err         sticky: partition returned a pivot outside its range
module quicksort_ctrl #(
  parameter int ARR_WIDTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ARR_WIDTH*4-1:0] array_in,
  input  logic                   sort_start,
  output logic [ARR_WIDTH*4-1:0] part_array_out,
  output logic [3:0]             part_lo_ind,
  output logic [3:0]             part_hi_ind,
  output logic                   part_start,
  input  logic [ARR_WIDTH*4-1:0] part_array_in,
  input  logic                   part_valid,
  input  logic [3:0]             part_pivot_ind,
  output logic [ARR_WIDTH*4-1:0] array_out,
  output logic                   sort_valid,
  output logic                   busy,
  output logic                   sort_err
);

  localparam int SPW = $clog2(ARR_WIDTH);
  localparam logic [3:0] LAST_IDX = 4'(ARR_WIDTH - 1);

  typedef logic [SPW:0] sp_t;
  typedef enum logic [2:0] {IDLE, POP, ISSUE, WAIT, PUSH, DONE} state_t;

  state_t                 state_q;
  sp_t                    sp_q;
  logic [7:0]             stack_q [ARR_WIDTH];
  logic [ARR_WIDTH*4-1:0] work_q;
  logic [ARR_WIDTH*4-1:0] arrayOut_q;
  logic [3:0]             curLo_q;
  logic [3:0]             curHi_q;
  logic [3:0]             pivot_q;
  logic [3:0]             partLo_q;
  logic [3:0]             partHi_q;
  logic                   partStart_q;
  logic                   sortValid_q;
  logic                   busy_q;
  logic                   sortErr_q;

  // Sub-range selection after a partition. The comparisons are widened to
  // five bits so a pivot at index 0 or 15 cannot wrap around.
  logic [4:0]     curLoW, curHiW, pivotW;
  logic           pushLeft, pushRight;
  logic [7:0]     leftEntry, rightEntry;
  logic [SPW-1:0] spIdx, spIdxP1, popIdx, rightIdx;

  always_comb begin
    curLoW     = {1'b0, curLo_q};
    curHiW     = {1'b0, curHi_q};
    pivotW     = {1'b0, pivot_q};
    pushLeft   = (pivotW >= curLoW + 5'd2);
    pushRight  = (pivotW + 5'd2 <= curHiW);
    leftEntry  = {curLo_q, pivot_q - 4'd1};
    rightEntry = {pivot_q + 4'd1, curHi_q};
    spIdx      = sp_q[SPW-1:0];
    spIdxP1    = spIdx + 1'b1;
    popIdx     = spIdx - 1'b1;
    // The right range lands above the left one when both are pushed.
    rightIdx   = pushLeft ? spIdxP1 : spIdx;
  end

  // Main controller FSM. All outputs are registered here. part_start and
  // sort_valid default low each cycle so that each is a single-cycle pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      sp_q        <= '0;
      work_q      <= '0;
      arrayOut_q  <= '0;
      curLo_q     <= '0;
      curHi_q     <= '0;
      pivot_q     <= '0;
      partLo_q    <= '0;
      partHi_q    <= '0;
      partStart_q <= 1'b0;
      sortValid_q <= 1'b0;
      busy_q      <= 1'b0;
      sortErr_q   <= 1'b0;
    end else begin
      partStart_q <= 1'b0;
      sortValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sort_start) begin
            work_q      <= array_in;
            stack_q[0]  <= {4'd0, LAST_IDX};
            sp_q        <= sp_t'(1);
            sortErr_q   <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= POP;
          end
        end
        POP: begin
          if (sp_q == '0) begin
            // The result and its pulse are set up here so that they are
            // visible during the DONE cycle itself.
            arrayOut_q  <= work_q;
            sortValid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            sp_q    <= sp_q - sp_t'(1);
            curLo_q <= stack_q[popIdx][7:4];
            curHi_q <= stack_q[popIdx][3:0];
            if (stack_q[popIdx][3:0] > stack_q[popIdx][7:4]) begin
              partLo_q    <= stack_q[popIdx][7:4];
              partHi_q    <= stack_q[popIdx][3:0];
              partStart_q <= 1'b1;
              state_q     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (part_valid) begin
            work_q  <= part_array_in;
            pivot_q <= part_pivot_ind;
            if (part_pivot_ind < curLo_q || part_pivot_ind > curHi_q) begin
              // A pivot outside its range means the stack can no longer be
              // trusted, so the sort is abandoned with what came back.
              sortErr_q   <= 1'b1;
              arrayOut_q  <= part_array_in;
              sortValid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= PUSH;
            end
          end
        end
        PUSH: begin
          if (pushLeft) begin
            stack_q[spIdx] <= leftEntry;
          end
          if (pushRight) begin
            stack_q[rightIdx] <= rightEntry;
          end
          sp_q    <= sp_q + sp_t'(pushLeft) + sp_t'(pushRight);
          state_q <= POP;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign part_array_out = work_q;
  assign part_lo_ind    = partLo_q;
  assign part_hi_ind    = partHi_q;
  assign part_start     = partStart_q;
  assign array_out      = arrayOut_q;
  assign sort_valid     = sortValid_q;
  assign busy           = busy_q;
  assign sort_err       = sortErr_q;

endmodule

// File: tb/tb_quicksort_ctrl.sv
// Testbench for quicksort_ctrl with four 4-bit elements. A behavioural Lomuto
// partition block answers each request after a fixed latency. Sorts are
// driven from a table of vectors and compared against hand-computed results.
// Hand-written sequences cover reset mid-sort and the initial reset state.
module tb_quicksort_ctrl;

  localparam int N   = 4;
  localparam int W   = N * 4;
  localparam int LAT = N + 2;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] array_in = '0;
  logic         sort_start = 1'b0;
  logic [W-1:0] part_array_out;
  logic [3:0]   part_lo_ind;
  logic [3:0]   part_hi_ind;
  logic         part_start;
  logic [W-1:0] part_array_in = '0;
  logic         part_valid = 1'b0;
  logic [3:0]   part_pivot_ind = '0;
  logic [W-1:0] array_out;
  logic         sort_valid;
  logic         busy;
  logic         sort_err;

  int errors = 0;
  int checks = 0;

  quicksort_ctrl #(.ARR_WIDTH(N)) dut (
    .clock          (clock),
    .reset          (reset),
    .array_in       (array_in),
    .sort_start     (sort_start),
    .part_array_out (part_array_out),
    .part_lo_ind    (part_lo_ind),
    .part_hi_ind    (part_hi_ind),
    .part_start     (part_start),
    .part_array_in  (part_array_in),
    .part_valid     (part_valid),
    .part_pivot_ind (part_pivot_ind),
    .array_out      (array_out),
    .sort_valid     (sort_valid),
    .busy           (busy),
    .sort_err       (sort_err)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] getEl(input logic [W-1:0] a, input int i);
    return a[4*(N-1-i) +: 4];
  endfunction

  function automatic logic [W-1:0] setEl(input logic [W-1:0] a, input int i,
                                          input logic [3:0] v);
    logic [W-1:0] r;
    r = a;
    r[4*(N-1-i) +: 4] = v;
    return r;
  endfunction

  // Reference Lomuto partition: pivot is the element at hi, strict less-than.
  task automatic lomuto(input logic [W-1:0] a, input logic [3:0] lo,
                        input logic [3:0] hi, output logic [W-1:0] r,
                        output logic [3:0] p);
    logic [3:0] pv, t;
    int i;
    r  = a;
    pv = getEl(r, int'(hi));
    i  = int'(lo);
    for (int j = int'(lo); j < int'(hi); j++) begin
      if (getEl(r, j) < pv) begin
        t = getEl(r, i);
        r = setEl(r, i, getEl(r, j));
        r = setEl(r, j, t);
        i++;
      end
    end
    t = getEl(r, i);
    r = setEl(r, i, getEl(r, int'(hi)));
    r = setEl(r, int'(hi), t);
    p = 4'(i);
  endtask

  // Partition block model. It sees a request on the falling edge and answers
  // LAT falling edges later with a one-cycle strobe. injectErr corrupts the
  // returned pivot index, and reset abandons any request in flight.
  bit           injectErr = 1'b0;
  bit           modelBusy = 1'b0;
  int           modelCnt  = 0;
  logic [W-1:0] modelArr;
  logic [3:0]   modelPiv;

  always @(negedge clock) begin
    part_valid = 1'b0;
    if (reset) begin
      modelBusy = 1'b0;
    end else if (modelBusy) begin
      modelCnt--;
      if (modelCnt == 0) begin
        part_array_in  = modelArr;
        part_pivot_ind = injectErr ? 4'd9 : modelPiv;
        part_valid     = 1'b1;
        modelBusy      = 1'b0;
      end
    end else if (part_start) begin
      lomuto(part_array_out, part_lo_ind, part_hi_ind, modelArr, modelPiv);
      modelCnt  = LAT;
      modelBusy = 1'b1;
    end
  end

  // Counts completion pulses and records the deepest stack seen in a sort.
  int validCount = 0;
  int spMax      = 0;

  always @(negedge clock) begin
    if (sort_valid) validCount++;
    if (int'(dut.sp_q) > spMax) spMax = int'(dut.sp_q);
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " array_out"}, 32'(array_out), 32'h0);
    checkOutput({tag, " part_array_out"}, 32'(part_array_out), 32'h0);
    checkOutput({tag, " part_lo_ind"}, 32'(part_lo_ind), 32'h0);
    checkOutput({tag, " part_hi_ind"}, 32'(part_hi_ind), 32'h0);
    checkOutput({tag, " part_start"}, 32'(part_start), 32'h0);
    checkOutput({tag, " sort_valid"}, 32'(sort_valid), 32'h0);
    checkOutput({tag, " busy"}, 32'(busy), 32'h0);
    checkOutput({tag, " sort_err"}, 32'(sort_err), 32'h0);
  endtask

  // Runs one sort. It records busy/sort_err one cycle after the start is
  // accepted and part_start one cycle later. When hammer is set it keeps
  // re-pulsing sort_start with a different array while the sort runs.
  task automatic applyStimulus(input logic [W-1:0] arr, input bit hammer,
                               output bit busyT1, output bit errT1,
                               output bit startT2, output bit timedOut);
    @(negedge clock);
    array_in   = arr;
    sort_start = 1'b1;
    validCount = 0;
    spMax      = 0;
    @(negedge clock);
    sort_start = 1'b0;
    busyT1     = busy;
    errT1      = sort_err;
    @(negedge clock);
    startT2 = part_start;
    timedOut = 1'b1;
    for (int c = 0; c < 500; c++) begin
      if (sort_valid) begin
        timedOut = 1'b0;
        break;
      end
      if (hammer) begin
        array_in   = 16'hFFFF;
        sort_start = (c % 5 == 0);
      end
      @(negedge clock);
    end
    sort_start = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  typedef struct {
    logic [W-1:0] arr;
    bit           hammer;
    bit           inject;
    logic [W-1:0] expOut;
    bit           expErr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit busyT1, errT1, startT2, timedOut;
    bit seen;

    vecs[0] = '{16'h3142, 1'b0, 1'b0, 16'h1234, 1'b0};
    vecs[1] = '{16'h1234, 1'b0, 1'b0, 16'h1234, 1'b0};
    vecs[2] = '{16'hFEDC, 1'b0, 1'b0, 16'hCDEF, 1'b0};
    vecs[3] = '{16'h7777, 1'b0, 1'b0, 16'h7777, 1'b0};
    vecs[4] = '{16'hF00F, 1'b0, 1'b0, 16'h00FF, 1'b0};
    vecs[5] = '{16'h3142, 1'b1, 1'b0, 16'h1234, 1'b0};
    // First partition of 3,1,4,2 yields 1,2,4,3 before the bad pivot aborts.
    vecs[6] = '{16'h3142, 1'b0, 1'b1, 16'h1243, 1'b1};
    vecs[7] = '{16'h1234, 1'b0, 1'b0, 16'h1234, 1'b0};

    repeat (2) @(negedge clock);
    checkResetOutputs("reset");
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      injectErr = vecs[v].inject;
      applyStimulus(vecs[v].arr, vecs[v].hammer, busyT1, errT1, startT2,
                    timedOut);
      $display("[TB] vector %0d: in=%h out=%h err=%0d", v, vecs[v].arr,
               array_out, sort_err);
      checkOutput($sformatf("v%0d timeout", v), 32'(timedOut), 32'h0);
      checkOutput($sformatf("v%0d busy T+1", v), 32'(busyT1), 32'h1);
      checkOutput($sformatf("v%0d sort_err cleared", v), 32'(errT1), 32'h0);
      checkOutput($sformatf("v%0d part_start T+2", v), 32'(startT2), 32'h1);
      checkOutput($sformatf("v%0d array_out", v), 32'(array_out),
                  32'(vecs[v].expOut));
      checkOutput($sformatf("v%0d sort_err", v), 32'(sort_err),
                  32'(vecs[v].expErr));
      checkOutput($sformatf("v%0d valid pulses", v), 32'(validCount), 32'h1);
      checkOutput($sformatf("v%0d busy idle", v), 32'(busy), 32'h0);
      checkOutput($sformatf("v%0d sp<=2", v), 32'(spMax <= 2), 32'h1);
    end
    injectErr = 1'b0;

    // Reset while waiting on the partition block.
    @(negedge clock);
    array_in   = 16'h3142;
    sort_start = 1'b1;
    @(negedge clock);
    sort_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      seen = part_start;
    end
    checkOutput("reset-seq part_start seen", 32'(seen), 32'h1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkResetOutputs("mid-sort reset");
    @(negedge clock);
    reset = 1'b0;

    applyStimulus(16'h2130, 1'b0, busyT1, errT1, startT2, timedOut);
    checkOutput("post-reset timeout", 32'(timedOut), 32'h0);
    checkOutput("post-reset array_out", 32'(array_out), 32'h0123);
    checkOutput("post-reset valid pulses", 32'(validCount), 32'h1);
    checkOutput("post-reset sort_err", 32'(sort_err), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
